mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit owning the HI/LO register pair. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from the execute stage. It drives `hi` and `lo` directly into the 32-bit result-select mux in front of register-file writeback, where they occupy the MFHI/MFLO data inputs. The controller stalls issue while `busy` is high.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-cycle operation request.
- `op`  in  3  operation code, sampled with `start`.
- `rs_val`  in  32  multiplicand, dividend, or MTHI/MTLO source.
- `rt_val`  in  32  multiplier or divisor.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  high while a multi-cycle operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.

## Operation
Op encoding:
- 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
- 110 and 111 are reserved: no effect, no `done`.

Request acceptance:
- `start` is accepted only in IDLE.
- `start` while `busy` is ignored. There is no queueing, and the in-flight operation is unaffected.

State machine: IDLE, CALC, FIX.
- IDLE -> CALC on an accepted mult/div. Operands are latched: absolute values for signed ops, plus sign flags.
- CALC runs 32 iterations using a 6-bit counter.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
- CALC -> FIX when the counter reaches 32.
- FIX -> IDLE. FIX applies sign correction and writes HI/LO.

Arithmetic rules:
- Multiply: HI:LO = 64-bit product, signed or unsigned per op.
- Divide: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- Divide by zero (DIV or DIVU): HI = `rs_val`, LO = 0xFFFFFFFF.
  - Still takes the full latency.
- MTHI and MTLO write only their own register, at the accept edge. They never raise `busy`.
- HI/LO are never modified except at the FIX edge or the MTHI/MTLO accept edge. Intermediate results stay in internal accumulators.

Reset:
- Reset asserted at any time, including mid-CALC, forces IDLE with counter = 0.
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.

## Timing
Edge E0 is the edge at which `start` is accepted.

Mult/div:
- `busy` = 1 from after E0 through E33.
- Iterations happen at E1..E32.
- FIX writes HI/LO at E33.
- `busy` = 0 and `done` = 1 in the cycle after E33. Result latency is 33 cycles.

MTHI/MTLO:
- The register updates at E0.
- `done` = 1 in the cycle after E0.
- `busy` stays 0.

Back-to-back:
- A `start` in the `done` cycle is accepted. The unit is IDLE in that cycle.
- `done` never lasts more than one cycle.

`busy` and `done` are registered outputs with no combinational input-to-output paths.

## Configuration
`MDU_FAST_MULT_EN`:
- Defined: MULT and MULTU compute the product combinationally. HI/LO are written at E1, `busy` is high only for the cycle after E0, and `done` is high in the cycle after E1.
- Undefined: multiplies use the 33-cycle iterative path.
- Divide behaviour is identical in both builds.

## Structure
Package `mdu_pkg` holds:
- op encoding localparams `MDU_MULT` .. `MDU_MTLO`;
- the state encoding for IDLE, CALC and FIX;
- `MDU_ITERS = 32`.

Sub-module `mdu_shift_core`:
- Combinational single-iteration step.
- Inputs: accumulator, operand, mode (mul/div).
- Outputs: next accumulator, next quotient or product bits.
- The top level owns state, counter, sign flags and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles HI = 0xFFFFFFFE, LO = 0x00000001; `done` high exactly 1 cycle.
- MULT 0xFFFFFFFD (-3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 -> HI = 100, LO = 0xFFFFFFFF, latency 33 cycles. Then signed 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- MTHI 0x12345678 then MTLO 0xCAFEBABE on consecutive cycles -> both registers updated, `busy` never high. Then a `start` at cycle 5 of a MULT is ignored, and HI/LO match the first op only.
- Reset_n pulsed low at cycle 10 of a DIVU -> `hi`, `lo`, `busy` and `done` all 0 immediately. A new MULTU 3 × 4 then yields LO = 12. Rerun with `MDU_FAST_MULT_EN` and expect `done` 2 cycles after `start`.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states,
// iteration count and datapath widths.
package mdu_pkg;

    localparam int unsigned MDU_XLEN  = 32;
    localparam int unsigned MDU_OP_W  = 3;
    localparam int unsigned MDU_CNT_W = 6;
    localparam int unsigned MDU_ITERS = 32;

    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'b000;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'b001;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'b010;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'b011;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'b100;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    // True for the ops that operate on two's-complement operands.
    function automatic logic mdu_is_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Single iteration of the multiply/divide datapath (purely combinational).
//   acc_i/acc_o     : upper accumulator (partial product high half / remainder)
//   wrk_i/wrk_o     : lower working word (multiplier bits / dividend->quotient)
//   operand_i       : multiplicand or divisor (magnitude)
//   div_mode_i      : 1 = restoring divide step, 0 = shift-add multiply step
module mdu_shift_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] wrk_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic             div_mode_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] wrk_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] trial;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set,
        // then shift the carry/sum/multiplier chain right by one.
        sum     = {1'b0, acc_i} + (wrk_i[0] ? {1'b0, operand_i} : '0);
        // Divide: shift next dividend bit into the remainder, try subtract.
        shifted = {acc_i, wrk_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand_i});
        // Result is below the divisor whenever fits is set, so WIDTH bits suffice.
        trial   = shifted[WIDTH-1:0] - operand_i;

        acc_o = '0;
        wrk_o = '0;
        if (div_mode_i) begin
            acc_o = fits ? trial : shifted[WIDTH-1:0];
            wrk_o = {wrk_i[WIDTH-2:0], fits};
        end else begin
            acc_o = sum[WIDTH:1];
            wrk_o = {sum[0], wrk_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Executes MULT, MULTU, DIV, DIVU (33-cycle latency) and MTHI, MTLO (1 cycle).
// Optional build macro MDU_FAST_MULT_EN: MULT/MULTU use a single-cycle
// combinational product instead of the iterative path.
// Ports:
//   Clk, Reset_n    : clock (rising edge), async active-low reset
//   start, op       : one-cycle request and its op code
//   rs_val, rt_val  : source operands
//   hi, lo          : HI/LO architectural registers
//   busy            : multi-cycle operation in flight
//   done            : one-cycle pulse after HI/LO were updated
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    rs_val,
    input  logic [WIDTH-1:0]    rt_val,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo,
    output logic                busy,
    output logic                done
);

    localparam int unsigned DW = 2 * WIDTH;

    mdu_state_e state_q, state_d;

    logic [MDU_CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     wrk_q, wrk_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic             accept;
    logic             is_mul_op;
    logic             is_div_op;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] abs_rs;
    logic [WIDTH-1:0] abs_rt;
    logic [WIDTH-1:0] core_acc;
    logic [WIDTH-1:0] core_wrk;
    logic [DW-1:0]    prod_raw;
    logic [DW-1:0]    prod_neg;
`ifdef MDU_FAST_MULT_EN
    logic [DW-1:0]    fast_prod;
`endif

    // Request decode and operand magnitudes for signed ops.
    always_comb begin
        accept    = start && (state_q == MDU_IDLE);
        is_mul_op = (op == MDU_MULT) || (op == MDU_MULTU);
        is_div_op = (op == MDU_DIV)  || (op == MDU_DIVU);
        rs_neg    = mdu_is_signed(op) && rs_val[WIDTH-1];
        rt_neg    = mdu_is_signed(op) && rt_val[WIDTH-1];
        abs_rs    = rs_neg ? -rs_val : rs_val;
        abs_rt    = rt_neg ? -rt_val : rt_val;
        cnt_nxt   = cnt_q + MDU_CNT_W'(1);
        prod_raw  = {acc_q, wrk_q};
        prod_neg  = -prod_raw;
    end

`ifdef MDU_FAST_MULT_EN
    assign fast_prod = DW'(abs_rs) * DW'(abs_rt);
`endif

    mdu_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .acc_i      (acc_q),
        .wrk_i      (wrk_q),
        .operand_i  (opnd_q),
        .div_mode_i (is_div_q),
        .acc_o      (core_acc),
        .wrk_o      (core_wrk)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept && is_div_op) begin
                    state_d = MDU_CALC;
                end else if (accept && is_mul_op) begin
`ifdef MDU_FAST_MULT_EN
                    state_d = MDU_FIX;
`else
                    state_d = MDU_CALC;
`endif
                end
            end
            MDU_CALC: begin
                if (cnt_nxt == MDU_CNT_W'(MDU_ITERS)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX:  state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    // Datapath and output next-values.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        busy_d    = (state_d != MDU_IDLE);

        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (is_mul_op) begin
                        acc_d     = '0;
                        wrk_d     = abs_rt;
                        opnd_d    = abs_rs;
                        is_div_d  = 1'b0;
                        neg_res_d = rs_neg ^ rt_neg;
                        neg_rem_d = 1'b0;
                        dz_d      = 1'b0;
`ifdef MDU_FAST_MULT_EN
                        {acc_d, wrk_d} = fast_prod;
`endif
                    end else if (is_div_op) begin
                        acc_d     = '0;
                        wrk_d     = abs_rs;
                        opnd_d    = abs_rt;
                        is_div_d  = 1'b1;
                        neg_res_d = rs_neg ^ rt_neg;
                        neg_rem_d = rs_neg;
                        dz_d      = (rt_val == '0);
                    end else if (op == MDU_MTHI) begin
                        hi_d   = rs_val;
                        done_d = 1'b1;
                    end else if (op == MDU_MTLO) begin
                        lo_d   = rs_val;
                        done_d = 1'b1;
                    end
                end
            end
            MDU_CALC: begin
                acc_d = core_acc;
                wrk_d = core_wrk;
                cnt_d = cnt_nxt;
            end
            MDU_FIX: begin
                cnt_d  = '0;
                done_d = 1'b1;
                if (is_div_q) begin
                    // Divide by zero: the remainder path already yields rs_val
                    // after sign restore; only the quotient is forced.
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                    lo_d = dz_q ? '1 : (neg_res_q ? -wrk_q : wrk_q);
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : prod_raw;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: table of ops with hand-computed
// HI/LO/latency, plus sequences for back-to-back, ignored start and reset.
module tb_mult_div_unit;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_applied = 0;
    int n_miss    = 0;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op; return cycles from the accept edge to done (-1 on timeout)
    // and busy as seen in the cycle after the accept edge. Ends at the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy0);
        @(negedge Clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge Clk);
        start = 1'b0;
        busy0 = busy;
        lat = -1;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge Clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        logic b0;
        logic [2:0]  lop;
        logic [31:0] lrs, lrt, lhi, llo;

        //            op      rs            rt            hi            lo            lat
        vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
        vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT};
        vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        vecs[3]  = '{3'b011, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, DIV_LAT};
        vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        vecs[5]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT};
        vecs[6]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT};
        vecs[7]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
        vecs[8]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MUL_LAT};
        vecs[9]  = '{3'b010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, DIV_LAT};
        vecs[10] = '{3'b100, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 0};
        vecs[11] = '{3'b101, 32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
        vecs[12] = '{3'b110, 32'h11111111, 32'h22222222, 32'h12345678, 32'hCAFEBABE, -1};
        vecs[13] = '{3'b001, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, MUL_LAT};
        vecs[14] = '{3'b111, 32'h33333333, 32'h44444444, 32'h00000001, 32'h23456780, -1};

        Reset_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        #1;
        chk("reset_hi",   hi,   32'h0);
        chk("reset_lo",   lo,   32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            lop = vecs[i].op; lrs = vecs[i].rs; lrt = vecs[i].rt;
            run_op(lop, lrs, lrt, lat, b0);
            chk($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), 32'(b0),  32'(vecs[i].lat >= 1));
            chk($sformatf("v%0d_hi", i),   hi,       vecs[i].hi);
            chk($sformatf("v%0d_lo", i),   lo,       vecs[i].lo);
            @(negedge Clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
        end

        // MTHI then MTLO on consecutive cycles; the second lands in the done cycle.
        @(negedge Clk);
        start = 1'b1; op = 3'b100; rs_val = 32'h12345678;
        @(negedge Clk);
        chk("mt_busy0", 32'(busy), 32'h0);
        chk("mt_done0", 32'(done), 32'h1);
        op = 3'b101; rs_val = 32'hCAFEBABE;
        @(negedge Clk);
        start = 1'b0;
        chk("mt_busy1", 32'(busy), 32'h0);
        chk("mt_done1", 32'(done), 32'h1);
        chk("mt_hi",    hi, 32'h12345678);
        chk("mt_lo",    lo, 32'hCAFEBABE);

        // A start during a long op is ignored (an accepted MTHI would show at once).
`ifdef MDU_FAST_MULT_EN
        lop = 3'b010; lrs = 32'hFFFFFF9C; lrt = 32'd7;  lhi = 32'hFFFFFFFE; llo = 32'hFFFFFFF2;
`else
        lop = 3'b000; lrs = 32'hFFFFFFFE; lrt = 32'd5;  lhi = 32'hFFFFFFFF; llo = 32'hFFFFFFF6;
`endif
        @(negedge Clk);
        start = 1'b1; op = lop; rs_val = lrs; rt_val = lrt;
        @(negedge Clk);
        start = 1'b0;
        repeat (4) @(negedge Clk);
        start = 1'b1; op = 3'b100; rs_val = 32'hDEADBEEF;
        chk("ign_hi_mid", hi, 32'h12345678);
        @(negedge Clk);
        start = 1'b0;
        chk("ign_hi_after", hi, 32'h12345678);
        chk("ign_busy",     32'(busy), 32'h1);
        lat = -1;
        for (int k = 5; k < 50; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge Clk);
        end
        chk("ign_lat", 32'(lat), 32'd33);
        chk("ign_hi",  hi, lhi);
        chk("ign_lo",  lo, llo);

        // Back-to-back: a start in the done cycle is accepted.
        run_op(3'b011, 32'd100, 32'd7, lat, b0);
        chk("b2b_lat", 32'(lat), 32'd33);
        start = 1'b1; op = 3'b101; rs_val = 32'h00000055;
        @(negedge Clk);
        start = 1'b0;
        chk("b2b_done", 32'(done), 32'h1);
        chk("b2b_hi",   hi, 32'd2);
        chk("b2b_lo",   lo, 32'h00000055);

        // Reset in the middle of a DIVU, then a fresh MULTU.
        @(negedge Clk);
        start = 1'b1; op = 3'b011; rs_val = 32'd1000; rt_val = 32'd3;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        chk("rst_busy_before", 32'(busy), 32'h1);
        Reset_n = 1'b0;
        #1;
        chk("rst_hi",   hi, 32'h0);
        chk("rst_lo",   lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_op(3'b001, 32'd3, 32'd4, lat, b0);
        chk("post_rst_lat", 32'(lat), 32'(MUL_LAT));
        chk("post_rst_hi",  hi, 32'd0);
        chk("post_rst_lo",  lo, 32'd12);
        @(negedge Clk);
        chk("post_rst_done_pulse", 32'(done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
